// File: rtl/ps2_mmio_rx_pkg.sv
// Shared definitions for the memory-mapped PS/2 receiver: FSM states,
// register offsets and STATUS bit layout.
package ps2_rx_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        PARITY,
        STOP
    } state_e;

    localparam logic ADDR_DATA   = 1'b0;
    localparam logic ADDR_STATUS = 1'b1;

    localparam int STAT_NOT_EMPTY  = 0;
    localparam int STAT_FULL       = 1;
    localparam int STAT_OVF        = 2;
    localparam int STAT_ERR        = 3;
    localparam int STAT_ERRCNT_LSB = 8;
    localparam int STAT_COUNT_LSB  = 16;

    localparam int CLR_OVF    = 2;
    localparam int CLR_ERR    = 3;
    localparam int CLR_ERRCNT = 4;

    // PS/2 uses odd parity over data+parity and a high stop bit.
    function automatic logic frame_ok(logic [7:0] d, logic p, logic stop);
        return stop && (^{d, p});
    endfunction

endpackage

// File: rtl/ps2_mmio_rx_if.sv
// CPU-side register bus for the PS/2 receiver: select, strobes, address,
// write data, registered read data and the interrupt line.
interface ps2_mmio_rx_if;
    logic        cs;
    logic        re;
    logic        we;
    logic        addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        irq;

    modport master (output cs, re, we, addr, wdata, input rdata, irq);
    modport slave  (input cs, re, we, addr, wdata, output rdata, irq);
endinterface

// File: rtl/ps2_mmio_rx_sync_fifo.sv
// Power-of-two synchronous FIFO with occupancy count; pushes while full are
// only accepted when a pop happens in the same cycle.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [WIDTH-1:0]           wdata,
    input  logic                       pop,
    output logic [WIDTH-1:0]           rdata,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    cnt;
    logic             do_push;
    logic             do_pop;

    assign full    = (cnt == CW'(DEPTH));
    assign empty   = (cnt == '0);
    assign count   = cnt;
    assign rdata   = mem[rd_ptr];
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

endmodule

// File: rtl/ps2_mmio_rx.sv
// Memory-mapped PS/2 keyboard receiver: synchroniser, glitch filter, frame FSM,
// scan-code FIFO and DATA/STATUS registers. Define PS2_RX_TIMEOUT_EN to abort stalled frames.
module ps2_mmio_rx
    import ps2_rx_pkg::*;
#(
    parameter int FIFO_DEPTH     = 8,
    parameter int FILT_LEN       = 4,
    parameter int TIMEOUT_CYCLES = 5000
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            ps2_clk,
    input  logic            ps2_data,
    ps2_mmio_rx_if.slave    bus
);
    localparam int FCNT_W = $clog2(FILT_LEN + 1);
    localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;

    function automatic logic [7:0] sat_inc8(logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    logic              ps2_clk_p0, ps2_clk_p1;
    logic              ps2_data_p0, ps2_data_p1;
    logic              filt_clk;
    logic [FCNT_W-1:0] filt_cnt;
    logic              filt_flip;
    logic              sample;

    state_e            state, state_d;
    logic [2:0]        bit_idx;
    logic [7:0]        shift;
    logic              par_bit;
    logic              frame_push;
    logic              frame_bad;
    logic              timeout;

    logic [7:0]        head;
    logic              full;
    logic              empty;
    logic [CNT_W-1:0]  count;
    logic              pop;

    logic              ovf, err;
    logic [7:0]        err_cnt, err_cnt_d;
    logic              rd_stb, wr_stat;
    logic              err_set, ovf_set;
    logic [31:0]       status_word;
    logic [31:0]       rdata_q;
    logic              irq_q;
    logic              unused_wdata;

    // stage p0/p1: two-flop synchroniser for the asynchronous keyboard lines
    always_ff @(posedge clk) begin
        if (!rst) begin
            ps2_clk_p0  <= 1'b1;
            ps2_clk_p1  <= 1'b1;
            ps2_data_p0 <= 1'b1;
            ps2_data_p1 <= 1'b1;
        end else begin
            ps2_clk_p0  <= ps2_clk;
            ps2_clk_p1  <= ps2_clk_p0;
            ps2_data_p0 <= ps2_data;
            ps2_data_p1 <= ps2_data_p0;
        end
    end

    // filter: level follows only after FILT_LEN consecutive differing samples
    assign filt_flip = (ps2_clk_p1 != filt_clk) && (filt_cnt == FCNT_W'(FILT_LEN - 1));
    assign sample    = filt_flip && filt_clk;

    always_ff @(posedge clk) begin
        if (!rst) begin
            filt_clk <= 1'b1;
            filt_cnt <= '0;
        end else if (ps2_clk_p1 == filt_clk) begin
            filt_cnt <= '0;
        end else if (filt_flip) begin
            filt_clk <= ps2_clk_p1;
            filt_cnt <= '0;
        end else begin
            filt_cnt <= filt_cnt + 1'b1;
        end
    end

`ifdef PS2_RX_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TO_W-1:0] to_cnt;

    assign timeout = (state != IDLE) && !sample && (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (!rst || state == IDLE || sample || timeout) begin
            to_cnt <= '0;
        end else begin
            to_cnt <= to_cnt + 1'b1;
        end
    end
`else
    logic unused_timeout_cycles;
    assign unused_timeout_cycles = (TIMEOUT_CYCLES != 0);
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    always_comb begin
        state_d    = state;
        frame_push = 1'b0;
        frame_bad  = 1'b0;
        if (timeout) begin
            state_d = IDLE;
        end else if (sample) begin
            case (state)
                IDLE:    if (!ps2_data_p1) state_d = DATA;
                DATA:    if (bit_idx == 3'd7) state_d = PARITY;
                PARITY:  state_d = STOP;
                STOP: begin
                    state_d = IDLE;
                    if (frame_ok(shift, par_bit, ps2_data_p1)) frame_push = 1'b1;
                    else                                       frame_bad  = 1'b1;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst || state == IDLE) begin
            bit_idx <= '0;
        end else if (sample && state == DATA) begin
            bit_idx <= bit_idx + 3'd1;
        end
    end

    // frame payload is LSB first, so shift in from the top
    always_ff @(posedge clk) begin
        if (sample && state == DATA)   shift   <= {ps2_data_p1, shift[7:1]};
        if (sample && state == PARITY) par_bit <= ps2_data_p1;
    end

    assign rd_stb  = bus.cs && bus.re;
    assign wr_stat = bus.cs && bus.we && (bus.addr == ADDR_STATUS);
    assign pop     = rd_stb && (bus.addr == ADDR_DATA) && !empty;
    assign ovf_set = frame_push && full && !pop;
    assign err_set = frame_bad || timeout;

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (frame_push),
        .wdata (shift),
        .pop   (pop),
        .rdata (head),
        .full  (full),
        .empty (empty),
        .count (count)
    );

    // a clear of err_cnt applies first so a simultaneous error still counts
    always_comb begin
        err_cnt_d = err_cnt;
        if (wr_stat && bus.wdata[CLR_ERRCNT]) err_cnt_d = 8'd0;
        if (err_set) err_cnt_d = sat_inc8(err_cnt_d);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            ovf     <= 1'b0;
            err     <= 1'b0;
            err_cnt <= 8'd0;
        end else begin
            ovf     <= ovf_set || (ovf && !(wr_stat && bus.wdata[CLR_OVF]));
            err     <= err_set || (err && !(wr_stat && bus.wdata[CLR_ERR]));
            err_cnt <= err_cnt_d;
        end
    end

    always_comb begin
        status_word = 32'd0;
        status_word[STAT_NOT_EMPTY] = !empty;
        status_word[STAT_FULL]      = full;
        status_word[STAT_OVF]       = ovf;
        status_word[STAT_ERR]       = err;
        status_word[STAT_ERRCNT_LSB +: 8] = err_cnt;
        status_word[STAT_COUNT_LSB +: 8]  = 8'(count);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            rdata_q <= 32'd0;
            irq_q   <= 1'b0;
        end else begin
            irq_q <= !empty;
            if (rd_stb) begin
                if (bus.addr == ADDR_DATA) begin
                    rdata_q <= empty ? 32'd0 : {23'd0, 1'b1, head};
                end else begin
                    rdata_q <= status_word;
                end
            end
        end
    end

    assign bus.rdata    = rdata_q;
    assign bus.irq      = irq_q;
    assign unused_wdata = ^{bus.wdata[31:5], bus.wdata[1:0]};

endmodule

// File: tb/tb_ps2_mmio_rx.sv
// Directed bench for ps2_mmio_rx: keyboard frames bit-banged at a scaled-down
// PS/2 rate, results read back through the DATA/STATUS registers.
module tb_ps2_mmio_rx;
    localparam int HALF = 20;
    localparam int TO   = 300;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic ps2_clk = 1'b1;
    logic ps2_data = 1'b1;

    int n_cmp = 0;
    int n_err = 0;

    ps2_mmio_rx_if bus();

    ps2_mmio_rx #(
        .FIFO_DEPTH     (8),
        .FILT_LEN       (4),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .ps2_clk  (ps2_clk),
        .ps2_data (ps2_data),
        .bus      (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    task automatic ps2_bit(input logic b);
        @(negedge clk) ps2_data = b;
        repeat (HALF) @(negedge clk);
        ps2_clk = 1'b0;
        repeat (HALF) @(negedge clk);
        ps2_clk = 1'b1;
    endtask

    task automatic send_bits(input logic [7:0] d, input int nbits);
        ps2_bit(1'b0);
        for (int i = 0; i < nbits; i++) ps2_bit(d[i]);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic flip_par);
        ps2_bit(1'b0);
        for (int i = 0; i < 8; i++) ps2_bit(d[i]);
        ps2_bit((~^d) ^ flip_par);
        ps2_bit(1'b1);
        repeat (HALF) @(negedge clk);
    endtask

    // Stop-bit falling edge becomes a sample point 2 sync + 4 filter cycles later;
    // the STATUS write is lined up with exactly that clock edge.
    task automatic send_frame_clr(input logic [7:0] d, input logic flip_par, input logic [31:0] clr);
        ps2_bit(1'b0);
        for (int i = 0; i < 8; i++) ps2_bit(d[i]);
        ps2_bit((~^d) ^ flip_par);
        @(negedge clk) ps2_data = 1'b1;
        repeat (HALF) @(negedge clk);
        ps2_clk = 1'b0;
        repeat (5) @(negedge clk);
        bus.cs = 1'b1; bus.we = 1'b1; bus.addr = 1'b1; bus.wdata = clr;
        @(negedge clk);
        bus.cs = 1'b0; bus.we = 1'b0; bus.wdata = 32'd0;
        repeat (HALF - 6) @(negedge clk);
        ps2_clk = 1'b1;
        repeat (HALF) @(negedge clk);
    endtask

    task automatic bus_read(input logic a, output logic [31:0] v);
        @(negedge clk);
        bus.cs = 1'b1; bus.re = 1'b1; bus.addr = a;
        @(negedge clk);
        bus.cs = 1'b0; bus.re = 1'b0;
        v = bus.rdata;
    endtask

    task automatic bus_write(input logic a, input logic [31:0] d);
        @(negedge clk);
        bus.cs = 1'b1; bus.we = 1'b1; bus.addr = a; bus.wdata = d;
        @(negedge clk);
        bus.cs = 1'b0; bus.we = 1'b0; bus.wdata = 32'd0;
    endtask

    task automatic test_reset();
        logic [31:0] v;
        rst = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (bus.rdata !== 32'd0) begin
            $display("FAIL reset_rdata: got %h want %h", bus.rdata, 32'd0); n_err++;
        end
        n_cmp++;
        if (bus.irq !== 1'b0) begin
            $display("FAIL reset_irq: got %b want 0", bus.irq); n_err++;
        end
        bus_read(1'b1, v);
        n_cmp++;
        if (v !== 32'd0) begin
            $display("FAIL reset_status: got %h want %h", v, 32'd0); n_err++;
        end
    endtask

    task automatic test_single_frame();
        logic [31:0] v;
        send_frame(8'h1C, 1'b0);
        n_cmp++;
        if (bus.irq !== 1'b1) begin
            $display("FAIL single_irq_set: got %b want 1", bus.irq); n_err++;
        end
        bus_read(1'b0, v);
        n_cmp++;
        if (v !== 32'h0000011C) begin
            $display("FAIL single_data: got %h want %h", v, 32'h0000011C); n_err++;
        end
        repeat (2) @(negedge clk);
        n_cmp++;
        if (bus.irq !== 1'b0) begin
            $display("FAIL single_irq_clr: got %b want 0", bus.irq); n_err++;
        end
        bus_read(1'b1, v);
        n_cmp++;
        if (v !== 32'd0) begin
            $display("FAIL single_status: got %h want %h", v, 32'd0); n_err++;
        end
    endtask

    task automatic test_bad_parity();
        logic [31:0] v;
        send_frame(8'h1C, 1'b1);
        bus_read(1'b1, v);
        n_cmp++;
        if (v !== 32'h00000108) begin
            $display("FAIL parity_status: got %h want %h", v, 32'h00000108); n_err++;
        end
        n_cmp++;
        if (bus.irq !== 1'b0) begin
            $display("FAIL parity_irq: got %b want 0", bus.irq); n_err++;
        end
        bus_write(1'b1, 32'h18);
        bus_read(1'b1, v);
        n_cmp++;
        if (v !== 32'd0) begin
            $display("FAIL parity_clear: got %h want %h", v, 32'd0); n_err++;
        end
    endtask

    task automatic test_overflow();
        logic [31:0] v;
        for (int i = 1; i <= 9; i++) send_frame(8'(i), 1'b0);
        bus_read(1'b1, v);
        n_cmp++;
        if (v !== 32'h00080007) begin
            $display("FAIL ovf_status: got %h want %h", v, 32'h00080007); n_err++;
        end
        for (int i = 1; i <= 8; i++) begin
            bus_read(1'b0, v);
            n_cmp++;
            if (v !== (32'h100 | 32'(i))) begin
                $display("FAIL ovf_read%0d: got %h want %h", i, v, 32'h100 | 32'(i)); n_err++;
            end
        end
        bus_read(1'b0, v);
        n_cmp++;
        if (v !== 32'd0) begin
            $display("FAIL ovf_read_empty: got %h want %h", v, 32'd0); n_err++;
        end
        bus_read(1'b1, v);
        n_cmp++;
        if (v !== 32'h00000004) begin
            $display("FAIL ovf_sticky: got %h want %h", v, 32'h4); n_err++;
        end
        bus_write(1'b1, 32'h4);
        bus_read(1'b1, v);
        n_cmp++;
        if (v !== 32'd0) begin
            $display("FAIL ovf_clear: got %h want %h", v, 32'd0); n_err++;
        end
    endtask

    task automatic test_glitch();
        logic [31:0] v;
        @(negedge clk);
        ps2_data = 1'b0; ps2_clk = 1'b0;
        repeat (2) @(negedge clk);
        ps2_clk = 1'b1; ps2_data = 1'b1;
        repeat (10) @(negedge clk);
        send_frame(8'h33, 1'b0);
        bus_read(1'b0, v);
        n_cmp++;
        if (v !== 32'h00000133) begin
            $display("FAIL glitch_data: got %h want %h", v, 32'h133); n_err++;
        end
        bus_read(1'b1, v);
        n_cmp++;
        if (v !== 32'd0) begin
            $display("FAIL glitch_status: got %h want %h", v, 32'd0); n_err++;
        end
    endtask

    task automatic test_timeout();
        logic [31:0] v;
        send_bits(8'h05, 4);
        repeat (2 * TO) @(negedge clk);
        bus_read(1'b1, v);
`ifdef PS2_RX_TIMEOUT_EN
        n_cmp++;
        if (v !== 32'h00000108) begin
            $display("FAIL timeout_status: got %h want %h", v, 32'h108); n_err++;
        end
`else
        n_cmp++;
        if (v !== 32'd0) begin
            $display("FAIL stall_status: got %h want %h", v, 32'd0); n_err++;
        end
        @(negedge clk) rst = 1'b0;
        @(negedge clk) rst = 1'b1;
`endif
        send_frame(8'hF0, 1'b0);
        bus_read(1'b0, v);
        n_cmp++;
        if (v !== 32'h000001F0) begin
            $display("FAIL timeout_next_frame: got %h want %h", v, 32'h1F0); n_err++;
        end
        bus_write(1'b1, 32'h18);
    endtask

    task automatic test_reset_mid_frame();
        logic [31:0] v;
        send_frame(8'h11, 1'b0);
        bus_read(1'b1, v);
        n_cmp++;
        if (v !== 32'h00010001) begin
            $display("FAIL midrst_pre_status: got %h want %h", v, 32'h00010001); n_err++;
        end
        send_bits(8'h0A, 4);
        @(negedge clk) rst = 1'b0;
        @(negedge clk) rst = 1'b1;
        n_cmp++;
        if (bus.rdata !== 32'd0) begin
            $display("FAIL midrst_rdata: got %h want %h", bus.rdata, 32'd0); n_err++;
        end
        n_cmp++;
        if (bus.irq !== 1'b0) begin
            $display("FAIL midrst_irq: got %b want 0", bus.irq); n_err++;
        end
        bus_read(1'b1, v);
        n_cmp++;
        if (v !== 32'd0) begin
            $display("FAIL midrst_status: got %h want %h", v, 32'd0); n_err++;
        end
        send_frame(8'h5A, 1'b0);
        bus_read(1'b0, v);
        n_cmp++;
        if (v !== 32'h0000015A) begin
            $display("FAIL midrst_next_frame: got %h want %h", v, 32'h15A); n_err++;
        end
    endtask

    task automatic test_clear_collision();
        logic [31:0] v;
        send_frame(8'h1C, 1'b1);
        send_frame_clr(8'h2B, 1'b0, 32'h08);
        bus_read(1'b1, v);
        n_cmp++;
        if (v !== 32'h00010101) begin
            $display("FAIL push_vs_clear_status: got %h want %h", v, 32'h00010101); n_err++;
        end
        bus_read(1'b0, v);
        n_cmp++;
        if (v !== 32'h0000012B) begin
            $display("FAIL push_vs_clear_data: got %h want %h", v, 32'h12B); n_err++;
        end
        send_frame_clr(8'h2B, 1'b1, 32'h18);
        bus_read(1'b1, v);
        n_cmp++;
        if (v !== 32'h00000108) begin
            $display("FAIL bad_vs_clear_status: got %h want %h", v, 32'h108); n_err++;
        end
    endtask

    initial begin
        bus.cs = 1'b0; bus.re = 1'b0; bus.we = 1'b0; bus.addr = 1'b0; bus.wdata = 32'd0;
        test_reset();
        test_single_frame();
        test_bad_parity();
        test_overflow();
        test_glitch();
        test_timeout();
        test_reset_mid_frame();
        test_clear_collision();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/ps2_mmio_rx.md
Name: ps2_mmio_rx

Overview:
Memory-mapped PS/2 keyboard receiver. It is the input-side counterpart of the CPU's display outputs (VGA, seven-segment).
- Deserialises PS/2 frames from the external keyboard.
- Buffers scan codes in a FIFO.
- Exposes DATA/STATUS registers on the CPU data bus, so programs can read keys the same way they write DataAdr/WriteData to the outputs.

Parameters:
FIFO_DEPTH, 8, scan-code FIFO entries (power of 2, 2..128)
FILT_LEN, 4, consecutive equal samples required before the filtered ps2_clk level changes
TIMEOUT_CYCLES, 5000, clk cycles without a ps2_clk falling edge that abort a frame in progress (100 us at 50 MHz)

Ports:
clk  input  1  system clock
rst  input  1  synchronous reset, active-low
ps2_clk  input  1  asynchronous keyboard clock
ps2_data  input  1  asynchronous keyboard data
cs  input  1  chip select from address decode
re  input  1  read strobe (valid with cs)
we  input  1  write strobe (valid with cs)
addr  input  1  word offset: 0=DATA, 1=STATUS
wdata  input  32  write data
rdata  output  32  read data, registered
irq  output  1  level interrupt: FIFO not empty

Behaviour:
- Reset state: rdata=0, irq=0, FIFO empty, ovf=0, err=0, err_cnt=0, FSM in IDLE.
- Reset is synchronous, sampled on posedge clk with rst=0. Reset mid-frame discards the partial frame.

Input conditioning:
- ps2_clk and ps2_data pass through a 2-flop synchroniser.
- Filtered clock changes level only after FILT_LEN identical synchronised samples.
- Sample point: filtered clock 1->0 transition. ps2_data (synchronised) is sampled on that same cycle.

FSM states (advance only on sample points):
- IDLE: bit=0 -> DATA with bit index 0; bit=1 -> stay IDLE (spurious edge).
- DATA: shift in 8 bits, LSB first; after bit 7 -> PARITY.
- PARITY: capture bit -> STOP.
- STOP: frame is good when stop=1 and popcount(data,parity) is odd.
  - Good frame: push byte to FIFO.
  - Bad frame: set err, err_cnt+=1 (8-bit, saturates at 255).
  - Either case -> IDLE.
- Timeout: in any state other than IDLE, a counter runs; it clears on each sample point. Reaching TIMEOUT_CYCLES -> IDLE, set err, err_cnt+=1.

FIFO:
- Push when full: byte dropped, ovf=1.
- Push and pop in the same cycle while full: both occur, count unchanged, no ovf.
- Push and pop in the same cycle while empty: push only.

Bus interface:
- Registers update on posedge clk, one cycle after cs&re; rdata holds the value until the next read.
- Read DATA: rdata={23'b0, valid, byte}. When not empty: valid=1 and the head entry is popped. When empty: rdata=0, no pop.
- Read STATUS: rdata[0]=not_empty, [1]=full, [2]=ovf, [3]=err, [15:8]=err_cnt, [23:16]=FIFO count, all other bits 0.
- Write STATUS (cs&we, addr=1): wdata[2]=1 clears ovf; wdata[3]=1 clears err; wdata[4]=1 clears err_cnt.
- Writes to DATA are ignored.
- A set event and a clear in the same cycle: set wins; err_cnt ends at 1.
- irq=not_empty, registered.

Optional Feature:
PS2_RX_TIMEOUT_EN
- Defined: timeout counter and abort behaviour exactly as above.
- Undefined: no counter. A stalled frame waits indefinitely in its current state; only reset recovers it.
- TIMEOUT_CYCLES is unused when the macro is undefined.

Decomposition:
- Package ps2_rx_pkg holds:
  - state enum (IDLE, DATA, PARITY, STOP)
  - register offsets ADDR_DATA=0, ADDR_STATUS=1
  - STATUS bit positions and clear-bit positions
- Sub-module sync_fifo (parameterised width/depth, push/pop/full/empty/count, synchronous active-low rst) holds the buffer.
- Synchroniser, filter, FSM and register file stay in ps2_mmio_rx.

Test Plan:
- Frame 0x1C (start 0; data bits 0,0,1,1,1,0,0,0; parity 0; stop 1) at 12.5 kHz, then read DATA -> rdata=0x0000011C, irq 1->0, STATUS count=0.
- Frame 0x1C with parity bit 1 -> FIFO stays empty; STATUS err=1, err_cnt=1. Then write STATUS wdata=0x18 -> err=0, err_cnt=0.
- Nine good frames 0x01..0x09 with no reads -> count=8, full=1, ovf=1. Eight DATA reads return 0x101..0x108; the ninth DATA read returns 0.
- 2-cycle low glitch on ps2_clk while IDLE -> no state change. Start bit + 4 data bits, then stall TIMEOUT_CYCLES (macro on) -> IDLE, err_cnt=1. Following frame 0xF0 (parity 1) -> DATA read returns 0x1F0.
- Assert rst=0 for one cycle after 5 bits of a frame -> all outputs 0, FIFO empty. Next complete frame 0x5A -> DATA read returns 0x15A.
- Good frame pushes in the same cycle as a STATUS clear of err while err was already set by a previous bad frame -> err becomes 0 and the byte is queued. Separately, a bad frame completing in the same cycle as a clear -> err=1, err_cnt=1.
